// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter sharing the data-memory port between CPU (m0) and aux master (m1)
// Optional statistics outputs are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_funct3,
  output logic        m0_rsp_valid,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_funct3,
  output logic        m1_rsp_valid,
  output logic [31:0] m1_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0] stat_grants0,
  output logic [31:0] stat_grants1,
  output logic [15:0] stat_wait_max,
`endif
  output logic        dmem_wren,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_data_in,
  output logic [2:0]  dmem_funct3,
  input  logic [31:0] dmem_data_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic [1:0] state;
  logic       rr_next;
  logic [3:0] burst_cnt;
  logic       gnt0;
  logic       gnt1;
  logic       burst_full;

  assign burst_full = (burst_cnt >= BURST_MAX);

  // The owner keeps the port until its burst is spent and the other side is waiting.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state)
        S_OWN0: begin
          if (m0_valid && !(m1_valid && burst_full)) gnt0 = 1'b1;
          else if (m1_valid)                         gnt1 = 1'b1;
        end
        S_OWN1: begin
          if (m1_valid && !(m0_valid && burst_full)) gnt1 = 1'b1;
          else if (m0_valid)                         gnt0 = 1'b1;
        end
        default: begin
          if (m0_valid && m1_valid) begin
            gnt0 = !rr_next;
            gnt1 = rr_next;
          end else begin
            gnt0 = m0_valid;
            gnt1 = m1_valid;
          end
        end
      endcase
    end
  end

  assign m0_ready = gnt0;
  assign m1_ready = gnt1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rr_next   <= 1'b0;
      burst_cnt <= 4'd0;
    end else if (gnt0) begin
      state <= S_OWN0;
      if (state != S_OWN0)  burst_cnt <= 4'd1;
      else if (!burst_full) burst_cnt <= burst_cnt + 4'd1;
    end else if (gnt1) begin
      state <= S_OWN1;
      if (state != S_OWN1)  burst_cnt <= 4'd1;
      else if (!burst_full) burst_cnt <= burst_cnt + 4'd1;
    end else begin
      if (state == S_OWN0)      rr_next <= 1'b1;
      else if (state == S_OWN1) rr_next <= 1'b0;
      state     <= S_IDLE;
      burst_cnt <= 4'd0;
    end
  end

  always_comb begin
    dmem_wren    = 1'b0;
    dmem_address = 32'd0;
    dmem_data_in = 32'd0;
    dmem_funct3  = 3'd0;
    if (gnt0) begin
      dmem_wren    = m0_we;
      dmem_address = m0_addr;
      dmem_data_in = m0_wdata;
      dmem_funct3  = m0_funct3;
    end else if (gnt1) begin
      dmem_wren    = m1_we;
      dmem_address = m1_addr;
      dmem_data_in = m1_wdata;
      dmem_funct3  = m1_funct3;
    end
  end

  // Read tag pipeline: one stage per cycle of memory read latency.
  logic [READ_LATENCY-1:0] pipe_v;
  logic [READ_LATENCY-1:0] pipe_tag;
  logic                    load_acc;
  logic                    rsp_v;
  logic                    rsp_tag;

  assign load_acc = (gnt0 && !m0_we) || (gnt1 && !m1_we);

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_v   <= '0;
      pipe_tag <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      pipe_v[0]   <= load_acc;
      pipe_tag[0] <= gnt1;
    end
  end

  assign rsp_v        = pipe_v[READ_LATENCY-1] && !reset;
  assign rsp_tag      = pipe_tag[READ_LATENCY-1];
  assign m0_rsp_valid = rsp_v && !rsp_tag;
  assign m1_rsp_valid = rsp_v && rsp_tag;
  assign m0_rdata     = m0_rsp_valid ? dmem_data_out : 32'd0;
  assign m1_rdata     = m1_rsp_valid ? dmem_data_out : 32'd0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] wait0;
  logic [15:0] wait1;
  logic [15:0] wait0_nx;
  logic [15:0] wait1_nx;
  logic [15:0] wait_big;

  always_comb begin
    wait0_nx = 16'd0;
    wait1_nx = 16'd0;
    if (m0_valid && !m0_ready) wait0_nx = (wait0 == 16'hFFFF) ? wait0 : wait0 + 16'd1;
    if (m1_valid && !m1_ready) wait1_nx = (wait1 == 16'hFFFF) ? wait1 : wait1 + 16'd1;
    wait_big = (wait0_nx > wait1_nx) ? wait0_nx : wait1_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants0  <= 32'd0;
      stat_grants1  <= 32'd0;
      stat_wait_max <= 16'd0;
      wait0         <= 16'd0;
      wait1         <= 16'd0;
    end else begin
      if (gnt0 && stat_grants0 != 32'hFFFF_FFFF) stat_grants0 <= stat_grants0 + 32'd1;
      if (gnt1 && stat_grants1 != 32'hFFFF_FFFF) stat_grants1 <= stat_grants1 + 32'd1;
      wait0 <= wait0_nx;
      wait1 <= wait1_nx;
      if (wait_big > stat_wait_max) stat_wait_max <= wait_big;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - bench for dmem_arbiter: two instances (read latency 1 and 2) against a behavioural model
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m0_valid, m0_we, m1_valid, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_funct3, m1_funct3;

  logic        a_r0, a_r1, a_rv0, a_rv1, a_wren;
  logic [31:0] a_rd0, a_rd1, a_addr, a_din, a_dout;
  logic [2:0]  a_f3;
  logic        b_r0, b_r1, b_rv0, b_rv1, b_wren;
  logic [31:0] b_rd0, b_rd1, b_addr, b_din, b_dout;
  logic [2:0]  b_f3;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] a_sg0, a_sg1, b_sg0, b_sg1;
  logic [15:0] a_swm, b_swm;
`endif

  dmem_arbiter #(.READ_LATENCY(1), .MAX_BURST(MAXB)) u_dut_a (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(a_r0), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_funct3(m0_funct3), .m0_rsp_valid(a_rv0), .m0_rdata(a_rd0),
    .m1_valid(m1_valid), .m1_ready(a_r1), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_funct3(m1_funct3), .m1_rsp_valid(a_rv1), .m1_rdata(a_rd1),
`ifdef DMEM_ARB_STATS_EN
    .stat_grants0(a_sg0), .stat_grants1(a_sg1), .stat_wait_max(a_swm),
`endif
    .dmem_wren(a_wren), .dmem_address(a_addr), .dmem_data_in(a_din), .dmem_funct3(a_f3),
    .dmem_data_out(a_dout)
  );

  dmem_arbiter #(.READ_LATENCY(2), .MAX_BURST(MAXB)) u_dut_b (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(b_r0), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_funct3(m0_funct3), .m0_rsp_valid(b_rv0), .m0_rdata(b_rd0),
    .m1_valid(m1_valid), .m1_ready(b_r1), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_funct3(m1_funct3), .m1_rsp_valid(b_rv1), .m1_rdata(b_rd1),
`ifdef DMEM_ARB_STATS_EN
    .stat_grants0(b_sg0), .stat_grants1(b_sg1), .stat_wait_max(b_swm),
`endif
    .dmem_wren(b_wren), .dmem_address(b_addr), .dmem_data_in(b_din), .dmem_funct3(b_f3),
    .dmem_data_out(b_dout)
  );

  // Memories: synchronous read (old data on same-edge write), one extra output stage for instance b.
  logic [31:0] mem_a [logic [31:0]];
  logic [31:0] mem_b [logic [31:0]];
  logic [31:0] mdl_mem [logic [31:0]];
  logic [31:0] b_d1;

  function automatic logic [31:0] dflt(input logic [31:0] addr);
    return addr ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [31:0] rd_a(input logic [31:0] addr);
    return mem_a.exists(addr) ? mem_a[addr] : dflt(addr);
  endfunction
  function automatic logic [31:0] rd_b(input logic [31:0] addr);
    return mem_b.exists(addr) ? mem_b[addr] : dflt(addr);
  endfunction
  function automatic logic [31:0] rd_m(input logic [31:0] addr);
    return mdl_mem.exists(addr) ? mdl_mem[addr] : dflt(addr);
  endfunction

  always @(posedge clk) begin
    a_dout <= rd_a(a_addr);
    b_d1   <= rd_b(b_addr);
    b_dout <= b_d1;
    if (a_wren) mem_a[a_addr] = a_din;
    if (b_wren) mem_b[b_addr] = b_din;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_owner = -1;
  int m_run = 0;
  int m_rr = 0;
  ev_t qa[$];
  ev_t qb[$];
  ev_t glog[$];
  ev_t rlog_a[$];
  ev_t rlog_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle model check; the model advances at the end, standing in for the next rising edge.
  always @(negedge clk) begin
    int g;
    int ov;
    logic v0, v1;
    logic ew; logic [31:0] ea, ed; logic [2:0] ef;
    ev_t ra, rb;
    logic ea_v, eb_v;
    v0 = m0_valid; v1 = m1_valid;
    g = -1;
    if (!reset) begin
      if (m_owner < 0) begin
        if (v0 && v1) g = m_rr;
        else if (v0) g = 0;
        else if (v1) g = 1;
      end else begin
        ov = (m_owner == 0) ? int'(v0) : int'(v1);
        if (ov != 0 && !(((m_owner == 0) ? v1 : v0) && m_run >= MAXB)) g = m_owner;
        else if ((m_owner == 0) ? v1 : v0) g = 1 - m_owner;
      end
    end
    ew = 1'b0; ea = 32'd0; ed = 32'd0; ef = 3'd0;
    if (g == 0) begin ew = m0_we; ea = m0_addr; ed = m0_wdata; ef = m0_funct3; end
    if (g == 1) begin ew = m1_we; ea = m1_addr; ed = m1_wdata; ef = m1_funct3; end
    chk("a_ready0", {31'd0, a_r0}, {31'd0, g == 0});
    chk("a_ready1", {31'd0, a_r1}, {31'd0, g == 1});
    chk("b_ready0", {31'd0, b_r0}, {31'd0, g == 0});
    chk("b_ready1", {31'd0, b_r1}, {31'd0, g == 1});
    chk("a_dmem_wren", {31'd0, a_wren}, {31'd0, ew});
    chk("a_dmem_addr", a_addr, ea);
    chk("a_dmem_din", a_din, ed);
    chk("a_dmem_f3", {29'd0, a_f3}, {29'd0, ef});
    chk("b_dmem_wren", {31'd0, b_wren}, {31'd0, ew});
    chk("b_dmem_addr", b_addr, ea);
    chk("b_dmem_din", b_din, ed);
    chk("b_dmem_f3", {29'd0, b_f3}, {29'd0, ef});

    ea_v = !reset && qa.size() > 0 && qa[0].cyc == cyc;
    eb_v = !reset && qb.size() > 0 && qb[0].cyc == cyc;
    ra = '{cyc, 0, 32'd0}; rb = '{cyc, 0, 32'd0};
    if (ea_v) ra = qa.pop_front();
    if (eb_v) rb = qb.pop_front();
    chk("a_rsp_valid0", {31'd0, a_rv0}, {31'd0, ea_v && ra.id == 0});
    chk("a_rsp_valid1", {31'd0, a_rv1}, {31'd0, ea_v && ra.id == 1});
    chk("a_rdata0", a_rd0, (ea_v && ra.id == 0) ? ra.data : 32'd0);
    chk("a_rdata1", a_rd1, (ea_v && ra.id == 1) ? ra.data : 32'd0);
    chk("b_rsp_valid0", {31'd0, b_rv0}, {31'd0, eb_v && rb.id == 0});
    chk("b_rsp_valid1", {31'd0, b_rv1}, {31'd0, eb_v && rb.id == 1});
    chk("b_rdata0", b_rd0, (eb_v && rb.id == 0) ? rb.data : 32'd0);
    chk("b_rdata1", b_rd1, (eb_v && rb.id == 1) ? rb.data : 32'd0);

    if (a_r0) glog.push_back('{cyc, 0, 32'd0});
    if (a_r1) glog.push_back('{cyc, 1, 32'd0});
    if (a_rv0) rlog_a.push_back('{cyc, 0, a_rd0});
    if (a_rv1) rlog_a.push_back('{cyc, 1, a_rd1});
    if (b_rv0) rlog_b.push_back('{cyc, 0, b_rd0});
    if (b_rv1) rlog_b.push_back('{cyc, 1, b_rd1});

    if (reset) begin
      m_owner = -1; m_run = 0; m_rr = 0;
      qa.delete(); qb.delete();
    end else if (g >= 0) begin
      if (ew) mdl_mem[ea] = ed;
      else begin
        qa.push_back('{cyc + 1, g, rd_m(ea)});
        qb.push_back('{cyc + 2, g, rd_m(ea)});
      end
      m_run = (g == m_owner) ? ((m_run < MAXB) ? m_run + 1 : m_run) : 1;
      m_owner = g;
    end else begin
      if (m_owner >= 0) m_rr = 1 - m_owner;
      m_owner = -1; m_run = 0;
    end
    cyc++;
  end

  task automatic drive(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
    m0_valid = v0; m0_we = we0; m0_addr = a0; m0_wdata = d0; m0_funct3 = 3'b010;
    m1_valid = v1; m1_we = we1; m1_addr = a1; m1_wdata = d1; m1_funct3 = 3'b100;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
  endtask

  task automatic clear_logs();
    glog.delete(); rlog_a.delete(); rlog_b.delete();
  endtask

  initial begin
    logic [11:0] seq;
    reset = 1'b1;
    mem_a[32'h100] = 32'hDEAD_BEEF;
    mem_b[32'h100] = 32'hDEAD_BEEF;
    mdl_mem[32'h100] = 32'hDEAD_BEEF;
    idle(2);
    reset = 1'b0;
    idle(1);

    // single m0 load
    clear_logs();
    drive(1, 0, 32'h100, 32'd0, 0, 0, 32'd0, 32'd0);
    idle(3);
    chk("t1_grants", glog.size(), 1);
    chk("t1_rsp_cnt_a", rlog_a.size(), 1);
    chk("t1_rsp_cnt_b", rlog_b.size(), 1);
    if (glog.size() == 1 && rlog_a.size() == 1 && rlog_b.size() == 1) begin
      chk("t1_rdata_a", rlog_a[0].data, 32'hDEAD_BEEF);
      chk("t1_id_a", rlog_a[0].id, 0);
      chk("t1_lat_a", rlog_a[0].cyc - glog[0].cyc, 1);
      chk("t1_lat_b", rlog_b[0].cyc - glog[0].cyc, 2);
    end

    // both valid from reset: 4/4/4 round robin
    reset = 1'b1; idle(1); reset = 1'b0;
    clear_logs();
    for (int i = 0; i < 12; i++)
      drive(1, 0, 32'h400 + 32'(i * 4), 32'd0, 1, 0, 32'h800 + 32'(i * 4), 32'd0);
    idle(4);
    seq = 12'b0000_1111_0000;
    chk("t2_grants", glog.size(), 12);
    chk("t2_rsps", rlog_a.size(), 12);
    for (int i = 0; i < 12 && i < glog.size(); i++)
      chk("t2_order", glog[i].id, {31'd0, seq[11 - i]});

    // store then load from the other requester
    clear_logs();
    drive(1, 1, 32'h200, 32'h1234_5678, 0, 0, 32'd0, 32'd0);
    drive(0, 0, 32'd0, 32'd0, 1, 0, 32'h200, 32'd0);
    idle(4);
    chk("t3_rsp_cnt_a", rlog_a.size(), 1);
    chk("t3_rsp_cnt_b", rlog_b.size(), 1);
    if (rlog_a.size() == 1 && rlog_b.size() == 1) begin
      chk("t3_rdata_a", rlog_a[0].data, 32'h1234_5678);
      chk("t3_id_a", rlog_a[0].id, 1);
      chk("t3_rdata_b", rlog_b[0].data, 32'h1234_5678);
    end

    // alternating loads every cycle
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1, 0, 32'h300 + 32'(i * 4), 32'd0, 0, 0, 32'd0, 32'd0);
      else            drive(0, 0, 32'd0, 32'd0, 1, 0, 32'h300 + 32'(i * 4), 32'd0);
    end
    idle(4);
    chk("t4_grants", glog.size(), 6);
    chk("t4_rsps_b", rlog_b.size(), 6);
    if (glog.size() == 6 && rlog_b.size() == 6) begin
      chk("t4_first_data", rlog_b[0].data, 32'hA5A5_0300);
      for (int i = 0; i < 6; i++) begin
        chk("t4_tag", rlog_b[i].id, i % 2);
        chk("t4_lat", rlog_b[i].cyc - glog[i].cyc, 2);
      end
    end

    // reset right after an m1 load accept
    clear_logs();
    drive(0, 0, 32'd0, 32'd0, 1, 0, 32'h500, 32'd0);
    reset = 1'b1;
    drive(1, 0, 32'h504, 32'd0, 1, 0, 32'h508, 32'd0);
    reset = 1'b0;
    drive(1, 0, 32'h50C, 32'd0, 1, 0, 32'h510, 32'd0);
    idle(4);
    chk("t5_grants", glog.size(), 2);
    chk("t5_rsps_a", rlog_a.size(), 1);
    chk("t5_rsps_b", rlog_b.size(), 1);
    if (glog.size() == 2 && rlog_b.size() == 1) begin
      chk("t5_post_grant", glog[1].id, 0);
      chk("t5_rsp_id", rlog_b[0].id, 0);
      chk("t5_rsp_data", rlog_b[0].data, 32'hA5A5_050C);
    end

    // m1 alone 20 cycles, then m0 joins with the burst already saturated
    clear_logs();
    for (int i = 0; i < 20; i++) drive(0, 0, 32'd0, 32'd0, 1, 0, 32'h600 + 32'(i * 4), 32'd0);
    drive(1, 0, 32'h700, 32'd0, 1, 0, 32'h6F0, 32'd0);
    idle(2);
    chk("t6_grants", glog.size(), 21);
    for (int i = 0; i < 21 && i < glog.size(); i++)
      chk("t6_order", glog[i].id, (i < 20) ? 1 : 0);

    // after m0 owned and released, the tie goes to m1
    clear_logs();
    drive(1, 0, 32'h900, 32'd0, 1, 0, 32'h904, 32'd0);
    idle(3);
    chk("t7_grants", glog.size(), 1);
    if (glog.size() == 1) chk("t7_winner", glog[0].id, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
